// File: rtl/aes_round_sched_if.sv
// ----------------------------------------------------------------------------
// aes_round_sched_if : block, ciphertext, round-datapath and key-store signals
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface aes_round_sched_if #(
  parameter int KW = 4
);
  logic            iStart;
  logic [0:127]    iData;
  logic            oReady;
  logic            oValid;
  logic [0:127]    oData;
  logic            iAck;
  logic [0:127]    oRound_state;
  logic [0:127]    iRound_state;
  logic            oLast;
  logic [KW-1:0]   oKey_idx;
  logic [0:127]    iKey;
  logic [KW-1:0]   oRound;

  modport master (
    output iStart, iData, iAck, iRound_state, iKey,
    input  oReady, oValid, oData, oRound_state, oLast, oKey_idx, oRound
  );

  modport slave (
    input  iStart, iData, iAck, iRound_state, iKey,
    output oReady, oValid, oData, oRound_state, oLast, oKey_idx, oRound
  );
endinterface

`default_nettype wire

// File: rtl/aes_round_sched.sv
// ----------------------------------------------------------------------------
// aes_round_sched : iterative AES encryption round scheduler (IDLE/RUN/HOLD)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_round_sched #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  wire logic          iClk,
  input  wire logic          iRst,
  aes_round_sched_if.slave   bus
);

  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_RUN  = 2'd1;
  localparam logic [1:0]    S_HOLD = 2'd2;
  localparam logic [KW-1:0] C_NR   = KW'(NR);
  localparam logic [KW-1:0] C_ONE  = KW'(1);

  logic [1:0]    fsm_q,   fsm_d;
  logic [0:127]  state_q, state_d;
  logic [KW-1:0] round_q, round_d;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      S_IDLE: begin
        // Initial AddRoundKey uses key 0, which the key store returns in IDLE.
        if (bus.iStart) begin
          state_d = bus.iData ^ bus.iKey;
          round_d = C_ONE;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        state_d = bus.iRound_state;
        if (round_q == C_NR) begin
          round_d = '0;
          fsm_d   = S_HOLD;
        end else begin
          round_d = round_q + C_ONE;
        end
      end
      S_HOLD: begin
        if (bus.iAck) begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Outputs depend on registered state only; iStart/iAck never reach them.
  assign bus.oReady       = (fsm_q == S_IDLE);
  assign bus.oValid       = (fsm_q == S_HOLD);
  assign bus.oData        = (fsm_q == S_HOLD) ? state_q : '0;
  assign bus.oRound_state = state_q;
  assign bus.oLast        = (fsm_q == S_RUN) && (round_q == C_NR);
  assign bus.oKey_idx     = (fsm_q == S_RUN) ? round_q : '0;
  assign bus.oRound       = round_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_sched.sv
// ----------------------------------------------------------------------------
// tb_aes_round_sched : directed known-answer bench with an AES round/key model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_aes_round_sched;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  aes_round_sched_if #(.KW(4)) b10 ();
  aes_round_sched_if #(.KW(4)) b14 ();

  aes_round_sched #(.NR(10), .KW(4)) u_dut10 (.iClk(iClk), .iRst(iRst), .bus(b10));
  aes_round_sched #(.NR(14), .KW(4)) u_dut14 (.iClk(iClk), .iRst(iRst), .bus(b14));

  logic [7:0]   sbox   [0:255];
  logic [127:0] rk10   [0:15];
  logic [127:0] rk14   [0:15];
  logic [127:0] rk_tmp [0:15];
  vec_t         vecs   [0:5];
  int           n_chk  = 0;
  int           n_fail = 0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  // Round datapath and key store the scheduler drives.
  assign b10.iKey         = rk10[b10.oKey_idx];
  assign b10.iRound_state = aes_round(b10.oRound_state, b10.iKey, b10.oLast);
  assign b14.iKey         = rk14[b14.oKey_idx];
  assign b14.iRound_state = aes_round(b14.oRound_state, b14.iKey, b14.oLast);

  task automatic build_sbox();
    logic [7:0] inv, y;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      y = inv ^ ((inv << 1) | (inv >> 7)) ^ ((inv << 2) | (inv >> 6))
              ^ ((inv << 3) | (inv >> 5)) ^ ((inv << 4) | (inv >> 4)) ^ 8'h63;
      sbox[x] = y;
    end
  endtask

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tmp[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic run10(input logic [127:0] pt, input logic [127:0] ct);
    chk("idle_ready", 128'(b10.oReady), 128'(1));
    chk("idle_key_idx", 128'(b10.oKey_idx), 128'(0));
    b10.iStart = 1'b1;
    b10.iData  = pt;
    tick();
    b10.iStart = 1'b0;
    b10.iData  = ~pt;
    for (int k = 1; k <= 11; k++) begin
      chk("busy_ready", 128'(b10.oReady), 128'(0));
      chk("last", 128'(b10.oLast), 128'(k == 10));
      chk("round", 128'(b10.oRound), 128'((k <= 10) ? k : 0));
      if (k <= 10) begin
        chk("key_idx", 128'(b10.oKey_idx), 128'(k));
        chk("early_valid", 128'(b10.oValid), 128'(0));
        tick();
      end else begin
        chk("valid", 128'(b10.oValid), 128'(1));
        chk("ciphertext", b10.oData, ct);
        chk("hold_key_idx", 128'(b10.oKey_idx), 128'(0));
      end
    end
  endtask

  task automatic ack10();
    b10.iAck = 1'b1;
    tick();
    b10.iAck = 1'b0;
    chk("ack_valid", 128'(b10.oValid), 128'(0));
    chk("ack_ready", 128'(b10.oReady), 128'(1));
    chk("ack_data", b10.oData, 128'(0));
  endtask

  task automatic load_key10(input logic [127:0] key);
    expand({key, 128'h0}, 4, 10);
    for (int r = 0; r < 16; r++) rk10[r] = rk_tmp[r];
  endtask

  task automatic test_backpressure();
    run10(vecs[1].pt, vecs[1].ct);
    for (int c = 0; c < 20; c++) begin
      chk("bp_valid", 128'(b10.oValid), 128'(1));
      chk("bp_data", b10.oData, vecs[1].ct);
      b10.iStart = (c == 5);
      b10.iData  = vecs[2].pt;
      tick();
    end
    b10.iStart = 1'b0;
    ack10();
    tick();
    chk("bp_no_queue_ready", 128'(b10.oReady), 128'(1));
    chk("bp_no_queue_round", 128'(b10.oRound), 128'(0));
  endtask

  task automatic test_back_to_back();
    int q[$];
    int nxt, outs, last_acc, e;
    logic acc;
    nxt = 1; outs = 0; last_acc = -1;
    b10.iAck   = 1'b1;
    b10.iStart = 1'b1;
    b10.iData  = vecs[1].pt;
    for (int cyc = 0; cyc < 90 && outs < 5; cyc++) begin
      acc = b10.oReady && b10.iStart;
      if (b10.oValid) begin
        if (q.size() == 0) begin
          chk("b2b_spurious_valid", 128'(1), 128'(0));
        end else begin
          e = q.pop_front();
          chk("b2b_ciphertext", b10.oData, vecs[e].ct);
        end
        outs++;
      end
      if (acc) begin
        if (last_acc >= 0) chk("b2b_period", 128'(cyc - last_acc), 128'(12));
        last_acc = cyc;
        q.push_back(nxt);
      end
      tick();
      if (acc) begin
        nxt++;
        if (nxt > 5) b10.iStart = 1'b0;
        else         b10.iData  = vecs[nxt].pt;
      end
    end
    b10.iAck   = 1'b0;
    b10.iStart = 1'b0;
    chk("b2b_count", 128'(outs), 128'(5));
    chk("b2b_ready_after", 128'(b10.oReady), 128'(1));
  endtask

  task automatic test_reset_mid();
    logic seen;
    b10.iStart = 1'b1;
    b10.iData  = vecs[3].pt;
    tick();
    b10.iStart = 1'b0;
    repeat (4) tick();
    chk("rst_at_round", 128'(b10.oRound), 128'(5));
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("rst_ready", 128'(b10.oReady), 128'(1));
    chk("rst_valid", 128'(b10.oValid), 128'(0));
    chk("rst_data", b10.oData, 128'(0));
    chk("rst_round", 128'(b10.oRound), 128'(0));
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (b10.oValid) seen = 1'b1;
      tick();
    end
    chk("rst_no_valid", 128'(seen), 128'(0));
    run10(vecs[2].pt, vecs[2].ct);
    ack10();
  endtask

  task automatic test_nr14();
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f}, 8, 14);
    for (int r = 0; r < 16; r++) rk14[r] = rk_tmp[r];
    chk("nr14_idle_ready", 128'(b14.oReady), 128'(1));
    b14.iStart = 1'b1;
    b14.iData  = 128'h00112233445566778899aabbccddeeff;
    tick();
    b14.iStart = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k <= 14) begin
        chk("nr14_early_valid", 128'(b14.oValid), 128'(0));
        chk("nr14_last", 128'(b14.oLast), 128'(k == 14));
        chk("nr14_key_idx", 128'(b14.oKey_idx), 128'(k));
        tick();
      end else begin
        chk("nr14_valid", 128'(b14.oValid), 128'(1));
        chk("nr14_ciphertext", b14.oData, 128'h8ea2b7ca516745bfeafc49904b496089);
      end
    end
    b14.iAck = 1'b1;
    tick();
    b14.iAck = 1'b0;
    chk("nr14_ack_valid", 128'(b14.oValid), 128'(0));
    chk("nr14_ack_ready", 128'(b14.oReady), 128'(1));
  endtask

  initial begin
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf};
    vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h43b1cd7f598ece23881b00e3ed030688};
    vecs[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hf69f2445df4f9b17ad2b417be66c3710, 128'h7b0c785e27e8ad3f8223207104725dd4};

    iRst = 1'b1;
    b10.iStart = 1'b0; b10.iAck = 1'b0; b10.iData = '0;
    b14.iStart = 1'b0; b14.iAck = 1'b0; b14.iData = '0;
    build_sbox();
    for (int r = 0; r < 16; r++) begin rk10[r] = '0; rk14[r] = '0; end
    tick();
    tick();
    iRst = 1'b0;

    chk("rst_ready10", 128'(b10.oReady), 128'(1));
    chk("rst_valid10", 128'(b10.oValid), 128'(0));
    chk("rst_data10", b10.oData, 128'(0));
    chk("rst_last10", 128'(b10.oLast), 128'(0));
    chk("rst_key_idx10", 128'(b10.oKey_idx), 128'(0));
    chk("rst_round10", 128'(b10.oRound), 128'(0));
    chk("rst_ready14", 128'(b14.oReady), 128'(1));
    chk("rst_valid14", 128'(b14.oValid), 128'(0));

    for (int i = 0; i < 6; i++) begin
      load_key10(vecs[i].key);
      run10(vecs[i].pt, vecs[i].ct);
      ack10();
      tick();
    end

    test_backpressure();
    test_back_to_back();
    tick();
    test_reset_mid();
    test_nr14();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
Iterative AES encryption round scheduler. It accepts one 128-bit plaintext block and performs the initial AddRoundKey internally. It then sequences the shared combinational round datapath for NR rounds: full rounds 1..NR-1, then the final round (SubBytes/ShiftRows/AddRoundKey, no MixColumns) selected via oLast. It fetches round keys by index from an external pre-expanded key store, and holds the ciphertext under a valid/ack output handshake.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256); must be 2..14.
KW, 4, width of round-key index; must satisfy 2^KW > NR.

Ports:
iClk  input  1  clock; all state updates on rising edge.
iRst  input  1  synchronous, active-high reset.
iStart  input  1  request to start a block; accepted only when oReady=1.
iData  input  [0:127]  plaintext, sampled in the accept cycle.
oReady  output  1  scheduler idle and able to accept iStart.
oValid  output  1  ciphertext valid on oData.
oData  output  [0:127]  ciphertext; stable while oValid=1.
iAck  input  1  consumer takes ciphertext when oValid=1.
oRound_state  output  [0:127]  state fed to round datapath (= internal state register).
iRound_state  input  [0:127]  combinational result from round datapath.
oLast  output  1  selects final-round datapath (no MixColumns).
oKey_idx  output  KW  round-key index to key store.
iKey  input  [0:127]  round key for oKey_idx, combinational same-cycle return.
oRound  output  KW  current round number (debug/status).

Behaviour:
- Registers: rState[0:127], rRound[KW-1:0], FSM {IDLE, RUN, HOLD}.
- Reset (iRst=1 at edge): FSM=IDLE, rState=0, rRound=0. Outputs after reset: oReady=1, oValid=0, oData=0, oLast=0, oKey_idx=0, oRound=0. Reset overrides all other inputs, including mid-RUN/HOLD; the in-flight block is discarded and no oValid is produced.
- IDLE: oReady=1, oKey_idx=0. On iStart=1: rState <= iData ^ iKey (key 0), rRound <= 1, FSM -> RUN. iStart=0: hold.
- RUN: oReady=0, oKey_idx=rRound, oRound_state=rState, oLast=(rRound==NR). Each cycle: rState <= iRound_state. If rRound<NR: rRound <= rRound+1, stay in RUN. If rRound==NR: FSM -> HOLD, rRound <= 0.
- HOLD: oValid=1, oData=rState, oReady=0, oLast=0, oKey_idx=0. On iAck=1: FSM -> IDLE. No accept on that same edge; earliest next accept is one cycle later. iAck=0: hold indefinitely, with oData stable.
- oData = rState in HOLD, 0 otherwise. oRound = rRound.
- Latency: accept edge at cycle 0. Rounds occupy cycles 1..NR. oValid is first high in cycle NR+1 (cycle 11 for NR=10). Minimum throughput is one block per NR+2 cycles.
- iStart in RUN/HOLD is ignored, not queued. iAck outside HOLD is ignored.
- iData and iKey are only sampled in the IDLE accept cycle. iRound_state is only sampled in RUN.
- oLast is high for exactly one cycle per block.
- All outputs are decoded from registered state only; there are no combinational paths from iStart/iAck to outputs.

Test Plan:
- FIPS-197 C.1: key store = expansion of 000102..0f. Pulse iStart with iData=00112233445566778899aabbccddeeff -> oValid rises exactly 11 cycles after accept, and oData=69c4e0d86a7b0430d8cdb78070b4c55a.
- Sequencing trace, same run: oKey_idx = 0 (IDLE), then 1..10 in cycles 1..10. oLast=1 only in cycle 10. oReady=0 in cycles 1..11.
- Backpressure: hold iAck=0 for 20 cycles after oValid -> oValid and oData stay constant. Pulse iStart=1 with different data during this time -> ignored. Assert iAck -> oValid=0 and oReady=1 the next cycle.
- Back-to-back: keep iStart=1 continuously with iAck=1 -> blocks accepted every 12 cycles. Each ciphertext matches its own plaintext; nothing is dropped or duplicated.
- Reset mid-operation: assert iRst at round 5 -> next cycle FSM=IDLE, oReady=1, oValid=0, oData=0. A new block then completes correctly with the 11-cycle latency.
- NR=14 build with the FIPS-197 C.3 AES-256 vector -> oData=8ea2b7ca516745bfeafc49904b496089, oValid 15 cycles after accept.
